// File: rtl/data_mem_responder.sv
// Responder side of the CPU data-memory port. It stores 32-bit words, applies
// byte write strobes, and answers reads after a fixed latency over valid/ready.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2    // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic [3:0]            strb_q;
  logic                  is_write_q;
  logic                  ready_q;
  logic                  valid_q;
  logic [31:0]           rdata_q;
  logic [31:0]           mem_q [DEPTH];
  logic                  commit_s;
  logic                  unused_addr_s;

  // Byte offset and bits above the word index alias onto the same storage.
  assign unused_addr_s = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};

  assign commit_s = (state_q == WAIT) && (cnt_q == 4'd0) && is_write_q;

  // Request sequencing: latch the request in IDLE, count down in WAIT, hold the read response in RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      wdata_q    <= 32'h0000_0000;
      strb_q     <= 4'b0000;
      is_write_q <= 1'b0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      rdata_q    <= 32'h0000_0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (MemRead || MemWrite) begin
            idx_q      <= Address[ADDR_WIDTH+1:2];
            wdata_q    <= Write_data;
            strb_q     <= Write_strb;
            is_write_q <= MemWrite;  // a write wins when both are raised
            cnt_q      <= CNT_LOAD;
            state_q    <= WAIT;
            ready_q    <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else if (is_write_q) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else begin
            rdata_q <= mem_q[idx_q];
            valid_q <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (Read_data_Ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Storage commit: only strobed byte lanes change; storage itself has no reset.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign Mem_Req_Ready   = ready_q;
  assign Read_data       = rdata_q;
  assign Read_data_Valid = valid_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scenario bench for data_mem_responder: a word model plus a queue of expected
// read data, popped when the responder presents Read_data_Valid.
module tb_data_mem_responder;
  localparam int ADDR_WIDTH = 10;
  localparam int LATENCY    = 2;
  localparam int BOUND      = 100;

  logic        clk;
  logic        rst;
  logic [31:0] Address;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [int];
  logic [31:0] exp_q [$];

  data_mem_responder #(.ADDR_WIDTH(ADDR_WIDTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .Address(Address), .MemWrite(MemWrite), .MemRead(MemRead),
    .Write_data(Write_data), .Write_strb(Write_strb), .Mem_Req_Ready(Mem_Req_Ready),
    .Read_data(Read_data), .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int widx(input logic [31:0] a);
    return int'(a[ADDR_WIDTH+1:2]);
  endfunction

  function automatic logic [31:0] model_get(input logic [31:0] a);
    if (model.exists(widx(a))) return model[widx(a)];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    w = model_get(a);
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    model[widx(a)] = w;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!Mem_Req_Ready && n < BOUND) begin
      @(posedge clk); #1; n++;
    end
    if (!Mem_Req_Ready) begin
      total++; bad++;
      $display("FAIL wait_ready: Mem_Req_Ready got %b want 1 within %0d cycles", Mem_Req_Ready, BOUND);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output int busy);
    wait_ready();
    Address = a; Write_data = d; Write_strb = s; MemWrite = 1'b1;
    @(posedge clk); #1;
    MemWrite = 1'b0;
    Address = $urandom; Write_data = $urandom; Write_strb = 4'($urandom);
    busy = 0;
    while (!Mem_Req_Ready && busy < BOUND) begin
      busy++; @(posedge clk); #1;
    end
    model_write(a, d, s);
  endtask

  task automatic do_read(input logic [31:0] a, input int hold,
                         output logic [31:0] got, output logic [31:0] expv, output int lat,
                         output bit stable, output logic vafter, output logic rafter, output bit kept);
    wait_ready();
    exp_q.push_back(model_get(a));
    Address = a; MemRead = 1'b1;
    @(posedge clk); #1;
    MemRead = 1'b0; Address = $urandom; Write_data = $urandom;
    lat = 0;
    while (!Read_data_Valid && lat < BOUND) begin
      @(posedge clk); #1; lat++;
    end
    got  = Read_data;
    expv = exp_q.pop_front();
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      MemWrite = 1'b1;
      @(posedge clk); #1;
      if (!Read_data_Valid || Read_data !== got || Mem_Req_Ready) stable = 1'b0;
    end
    MemWrite = 1'b0;
    Read_data_Ready = 1'b1;
    @(posedge clk); #1;
    Read_data_Ready = 1'b0;
    vafter = Read_data_Valid;
    rafter = Mem_Req_Ready;
    kept   = (Read_data === got);
  endtask

  task automatic test_reset();
    int vcount = 0;
    rst = 1'b0; Address = 32'h0; MemWrite = 1'b0; MemRead = 1'b0;
    Write_data = 32'h0; Write_strb = 4'h0; Read_data_Ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    total++; if (Mem_Req_Ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", Mem_Req_Ready); end
    total++; if (Read_data_Valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", Read_data_Valid); end
    total++; if (Read_data !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 00000000", Read_data); end
    repeat (20) begin
      @(posedge clk); #1;
      if (Read_data_Valid !== 1'b0) vcount++;
    end
    total++; if (vcount != 0) begin bad++; $display("FAIL idle_valid: got %0d valid cycles want 0", vcount); end
  endtask

  task automatic test_write_read();
    int busy, lat; logic [31:0] got, expv; bit st, kp; logic va, ra;
    do_write(32'h10, 32'hDEAD_BEEF, 4'b1111, busy);
    total++; if (busy != LATENCY) begin bad++; $display("FAIL write_busy: got %0d want %0d", busy, LATENCY); end
    do_read(32'h10, 0, got, expv, lat, st, va, ra, kp);
    total++; if (lat != LATENCY) begin bad++; $display("FAIL read_latency: got %0d want %0d", lat, LATENCY); end
    total++; if (got !== expv) begin bad++; $display("FAIL read_full: got %h want %h", got, expv); end
  endtask

  task automatic test_strobes();
    int busy, lat; logic [31:0] got, expv; bit st, kp; logic va, ra;
    do_write(32'h10, 32'h1122_3344, 4'b0101, busy);
    do_read(32'h10, 0, got, expv, lat, st, va, ra, kp);
    total++; if (got !== expv) begin bad++; $display("FAIL strobe_0101: got %h want %h", got, expv); end
    do_write(32'h10, 32'h5555_5555, 4'b0000, busy);
    total++; if (busy != LATENCY) begin bad++; $display("FAIL strobe_0000_busy: got %0d want %0d", busy, LATENCY); end
    do_read(32'h10, 0, got, expv, lat, st, va, ra, kp);
    total++; if (got !== expv) begin bad++; $display("FAIL strobe_0000: got %h want %h", got, expv); end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] got, expv; bit st, kp; logic va, ra;
    do_read(32'h10, 5, got, expv, lat, st, va, ra, kp);
    total++; if (got !== expv) begin bad++; $display("FAIL bp_data: got %h want %h", got, expv); end
    total++; if (st !== 1'b1) begin bad++; $display("FAIL bp_stable: got %b want 1", st); end
    total++; if (va !== 1'b0) begin bad++; $display("FAIL bp_valid_drop: got %b want 0", va); end
    total++; if (ra !== 1'b1) begin bad++; $display("FAIL bp_ready_rise: got %b want 1", ra); end
    total++; if (kp !== 1'b1) begin bad++; $display("FAIL bp_data_kept: got %b want 1", kp); end
  endtask

  task automatic test_alias();
    int busy, lat; logic [31:0] got, expv; bit st, kp; logic va, ra;
    do_write(32'h0000_1004, 32'hCAFE_F00D, 4'b1111, busy);
    do_read(32'h0000_0007, 0, got, expv, lat, st, va, ra, kp);
    total++; if (got !== expv) begin bad++; $display("FAIL alias_wrap: got %h want %h", got, expv); end
  endtask

  task automatic test_reset_mid_op();
    int busy, lat; logic [31:0] got, expv; bit st, kp; logic va, ra;
    do_write(32'h20, 32'hAAAA_AAAA, 4'b1111, busy);
    wait_ready();
    Address = 32'h20; Write_data = 32'h1234_5678; Write_strb = 4'b1111; MemWrite = 1'b1;
    @(posedge clk); #1;
    MemWrite = 1'b0;
    rst = 1'b0; #1;
    total++; if (Read_data_Valid !== 1'b0) begin bad++; $display("FAIL rstw_valid: got %b want 0", Read_data_Valid); end
    total++; if (Mem_Req_Ready !== 1'b1) begin bad++; $display("FAIL rstw_ready: got %b want 1", Mem_Req_Ready); end
    @(posedge clk); #1 rst = 1'b1;
    do_read(32'h20, 0, got, expv, lat, st, va, ra, kp);
    total++; if (got !== expv) begin bad++; $display("FAIL rstw_dropped: got %h want %h", got, expv); end
    wait_ready();
    exp_q.push_back(model_get(32'h20));
    Address = 32'h20; MemRead = 1'b1;
    @(posedge clk); #1;
    MemRead = 1'b0;
    lat = 0;
    while (!Read_data_Valid && lat < BOUND) begin
      @(posedge clk); #1; lat++;
    end
    expv = exp_q.pop_front();
    total++; if (Read_data !== expv) begin bad++; $display("FAIL rstr_presented: got %h want %h", Read_data, expv); end
    rst = 1'b0; #1;
    total++; if (Read_data_Valid !== 1'b0) begin bad++; $display("FAIL rstr_valid: got %b want 0", Read_data_Valid); end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_both_requests();
    int busy = 0; int vseen = 0; int lat; logic [31:0] got, expv; bit st, kp; logic va, ra;
    wait_ready();
    Address = 32'h30; Write_data = 32'h0BAD_F00D; Write_strb = 4'b1111;
    MemWrite = 1'b1; MemRead = 1'b1;
    @(posedge clk); #1;
    MemWrite = 1'b0; MemRead = 1'b0;
    while (!Mem_Req_Ready && busy < BOUND) begin
      if (Read_data_Valid) vseen++;
      busy++; @(posedge clk); #1;
    end
    repeat (3) begin
      if (Read_data_Valid) vseen++;
      @(posedge clk); #1;
    end
    model_write(32'h30, 32'h0BAD_F00D, 4'b1111);
    total++; if (busy != LATENCY) begin bad++; $display("FAIL both_busy: got %0d want %0d", busy, LATENCY); end
    total++; if (vseen != 0) begin bad++; $display("FAIL both_no_resp: got %0d valid cycles want 0", vseen); end
    do_read(32'h30, 0, got, expv, lat, st, va, ra, kp);
    total++; if (got !== expv) begin bad++; $display("FAIL both_as_write: got %h want %h", got, expv); end
  endtask

  task automatic test_back_to_back();
    int busy, lat; logic [31:0] got, expv, a; bit st, kp; logic va, ra;
    for (int i = 0; i < 4; i++) do_write(32'h40 + 32'(4*i), $urandom, 4'b1111, busy);
    for (int i = 0; i < 30; i++) begin
      a = {20'($urandom), 10'(16 + $urandom_range(0, 3)), 2'($urandom)};
      if ($urandom_range(0, 1) == 0) begin
        do_write(a, $urandom, 4'($urandom), busy);
        total++; if (busy != LATENCY) begin bad++; $display("FAIL b2b_busy[%0d]: got %0d want %0d", i, busy, LATENCY); end
      end else begin
        do_read(a, $urandom_range(0, 2), got, expv, lat, st, va, ra, kp);
        total++; if (got !== expv || lat != LATENCY) begin
          bad++; $display("FAIL b2b_read[%0d]: got %h lat %0d want %h lat %0d", i, got, lat, expv, LATENCY);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobes();
    test_backpressure();
    test_alias();
    test_reset_mid_op();
    test_both_requests();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
